// File: rtl/ping_pong_counter_param.sv
// ping_pong_counter_param: up/down bounce or wrap counter with run-time bounds, step, flip and status pulses
module ping_pong_counter_param #(
  parameter int WIDTH   = 4,
  parameter int DEF_MIN = 0,
  parameter int DEF_MAX = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             mode,
  input  logic [WIDTH-1:0] step,
  input  logic             flip,
  input  logic             load_bounds,
  input  logic [WIDTH-1:0] min_in,
  input  logic [WIDTH-1:0] max_in,
  output logic [WIDTH-1:0] out,
  output logic             direction,
  output logic             at_min,
  output logic             at_max,
  output logic             turn,
  output logic             bound_err
);
  logic [WIDTH-1:0] out_q, out_d, min_q, min_d, max_q, max_d, s, dn;
  logic [WIDTH:0] up, min_s;
  logic dir_q, dir_d, turn_q, turn_d, err_q, err_d, hit_max, hit_min;
  // next-state selection; the extra top bit keeps out+s and min+s from aliasing
  always_comb begin
    s = (step == '0) ? WIDTH'(1) : step;
    up = {1'b0, out_q} + {1'b0, s};
    min_s = {1'b0, min_q} + {1'b0, s};
    dn = out_q - s;
    hit_max = up >= {1'b0, max_q};
    hit_min = {1'b0, out_q} <= min_s;
    out_d = out_q;
    dir_d = dir_q;
    min_d = min_q;
    max_d = max_q;
    turn_d = 1'b0;
    err_d = 1'b0;
    if (load_bounds) begin
      err_d = min_in >= max_in;
      if (!err_d) begin
        min_d = min_in;
        max_d = max_in;
        if (out_q < min_in || out_q > max_in) begin
          out_d = min_in;
          dir_d = 1'b1;
        end
      end
    end else if (flip) begin
      dir_d = ~dir_q;
    end else if (enable && !mode) begin
      out_d = dir_q ? (hit_max ? max_q : up[WIDTH-1:0]) : (hit_min ? min_q : dn);
      turn_d = dir_q ? hit_max : hit_min;
      dir_d = turn_d ? ~dir_q : dir_q;
    end else if (enable) begin
      turn_d = dir_q ? (out_q == max_q) : (out_q == min_q);
      out_d = dir_q ? (turn_d ? min_q : (hit_max ? max_q : up[WIDTH-1:0]))
                    : (turn_d ? max_q : (hit_min ? min_q : dn));
    end
  end
  // state and registered pulse outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= WIDTH'(DEF_MIN);
      dir_q <= 1'b1;
      min_q <= WIDTH'(DEF_MIN);
      max_q <= WIDTH'(DEF_MAX);
      turn_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      out_q <= out_d;
      dir_q <= dir_d;
      min_q <= min_d;
      max_q <= max_d;
      turn_q <= turn_d;
      err_q <= err_d;
    end
  end
  assign out = out_q;
  assign direction = dir_q;
  assign at_min = out_q == min_q;
  assign at_max = out_q == max_q;
  assign turn = turn_q;
  assign bound_err = err_q;
endmodule

// File: tb/tb_ping_pong_counter_param.sv
// tb_ping_pong_counter_param: scoreboard bench for 4-bit and 8-bit counter instances
module tb_ping_pong_counter_param;
  typedef struct {
    string name;
    bit w8;
    logic [7:0] out;
    logic dir, amin, amax, turn, err;
  } exp_t;
  exp_t q[$];
  logic clk = 0, rst = 1, en = 0, mode = 0, flip = 0, lb = 0;
  logic [7:0] step = 0, mn = 0, mx = 0;
  logic [3:0] o4;
  logic [7:0] o8;
  logic d4, amin4, amax4, t4, e4, d8, amin8, amax8, t8, e8;
  logic [7:0] emin = 0, emax = 15;
  bit w8 = 0;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  ping_pong_counter_param dut4 (
    .clk(clk), .rst(rst), .enable(en), .mode(mode), .step(step[3:0]), .flip(flip),
    .load_bounds(lb), .min_in(mn[3:0]), .max_in(mx[3:0]), .out(o4), .direction(d4),
    .at_min(amin4), .at_max(amax4), .turn(t4), .bound_err(e4));

  ping_pong_counter_param #(.WIDTH(8), .DEF_MIN(0), .DEF_MAX(255)) dut8 (
    .clk(clk), .rst(rst), .enable(en), .mode(mode), .step(step), .flip(flip),
    .load_bounds(lb), .min_in(mn), .max_in(mx), .out(o8), .direction(d8),
    .at_min(amin8), .at_max(amax8), .turn(t8), .bound_err(e8));

  task automatic cyc(input string nm, input logic r, e, m, f, l, input logic [7:0] st, a, b,
                     input logic [7:0] eo, input logic ed, et, ee);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; mode = m; flip = f; lb = l; step = st; mn = a; mx = b;
    x.name = nm; x.w8 = w8; x.out = eo; x.dir = ed;
    x.amin = eo == emin; x.amax = eo == emax; x.turn = et; x.err = ee;
    q.push_back(x);
  endtask

  task automatic run(input string nm, input logic m, input logic [7:0] st, eo, input logic ed, et);
    cyc(nm, 0, 1, m, 0, 0, st, 0, 0, eo, ed, et, 0);
  endtask

  task automatic rs(input string nm);
    emin = 0;
    emax = w8 ? 8'd255 : 8'd15;
    cyc(nm, 1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
  endtask

  // monitor: compare the DUT outputs produced by the edge following each queued stimulus
  initial begin
    exp_t x;
    logic [12:0] act, req;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        act = x.w8 ? {o8, d8, amin8, amax8, t8, e8} : {4'b0, o4, d4, amin4, amax4, t4, e4};
        req = {x.out, x.dir, x.amin, x.amax, x.turn, x.err};
        n_chk++;
        if (act !== req) begin
          n_fail++;
          $display("FAIL %s: got out=%0d dir=%b amin=%b amax=%b turn=%b err=%b, want out=%0d dir=%b amin=%b amax=%b turn=%b err=%b",
                   x.name, act[12:5], act[4], act[3], act[2], act[1], act[0],
                   req[12:5], req[4], req[3], req[2], req[1], req[0]);
        end
      end
    end
  end

  initial begin
    logic [7:0] seq2 [9] = '{5, 8, 11, 12, 9, 6, 3, 2, 5};
    logic dir2 [9] = '{1, 1, 1, 0, 0, 0, 0, 1, 1};
    rs("reset");
    for (int i = 1; i <= 15; i++) run("t1_up", 0, 1, 8'(i), i != 15, i == 15);
    for (int i = 14; i >= 0; i--) run("t1_down", 0, 1, 8'(i), i == 0, i == 0);
    run("t1_rebound", 0, 1, 1, 1, 0);
    emin = 2; emax = 12;
    cyc("t2_load", 0, 1, 0, 0, 1, 3, 2, 12, 2, 1, 0, 0);
    for (int i = 0; i < 9; i++) run("t2_step3", 0, 3, seq2[i], dir2[i], seq2[i] == 12 || seq2[i] == 2);
    rs("t3_reset");
    emin = 3; emax = 6;
    cyc("t3_load", 0, 0, 1, 0, 1, 1, 3, 6, 3, 1, 0, 0);
    run("t3_wrap", 1, 1, 4, 1, 0);
    run("t3_wrap", 1, 1, 5, 1, 0);
    run("t3_wrap", 1, 1, 6, 1, 0);
    run("t3_wrap_turn", 1, 1, 3, 1, 1);
    run("t3_wrap", 1, 1, 4, 1, 0);
    cyc("t3_flip", 0, 0, 1, 1, 0, 1, 0, 0, 4, 0, 0, 0);
    run("t3_wrap_dn", 1, 1, 3, 0, 0);
    run("t3_wrap_dn_turn", 1, 1, 6, 0, 1);
    run("t3_wrap_dn", 1, 1, 5, 0, 0);
    cyc("t4_equal", 0, 1, 1, 0, 1, 1, 9, 9, 5, 0, 0, 1);
    cyc("t4_inverted", 0, 1, 1, 0, 1, 1, 10, 4, 5, 0, 0, 1);
    run("t4_bounds_kept", 1, 1, 4, 0, 0);
    emin = 0; emax = 12;
    cyc("t5_load_inrange", 0, 0, 0, 0, 1, 1, 0, 12, 4, 0, 0, 0);
    cyc("t5_flip", 0, 0, 0, 1, 0, 1, 0, 0, 4, 1, 0, 0);
    for (int i = 5; i <= 7; i++) run("t5_up", 0, 1, 8'(i), 1, 0);
    cyc("t5_flip_en", 0, 1, 0, 1, 0, 1, 0, 0, 7, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("t5_hold", 0, 0, 0, 0, 0, 1, 0, 0, 7, 0, 0, 0);
    rs("t5_reset_mid");
    run("t5_default_max", 0, 14, 14, 1, 0);
    run("t5_hit_15", 0, 14, 15, 0, 1);
    run("t5_step0", 0, 0, 14, 0, 0);
    w8 = 1;
    rs("t6_reset");
    run("t6_200", 0, 200, 200, 1, 0);
    run("t6_255", 0, 200, 255, 0, 1);
    run("t6_55", 0, 200, 55, 0, 0);
    run("t6_0", 0, 200, 0, 1, 1);
    @(negedge clk);
    en = 0;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
